// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - decoupled instruction fetch stage with request credits and fetch queue
// Ports:
//   clk, rst_n                           clock, synchronous active-low reset
//   jalr_taken/target                    redirect from EX (highest priority)
//   branch_taken/target                  redirect from EX
//   jal_taken/target                     redirect from ID (lowest priority)
//   imem_req_valid/ready/addr            fetch request channel to instruction memory
//   imem_rsp_valid/data                  in-order response channel, no backpressure
//   id_valid/ready, id_pc, id_pc_plus_4, id_instr   fetch-queue head towards ID
module if_fetch_unit #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     FQ_DEPTH        = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jalr_taken,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jal_taken,
  input  logic [XLEN-1:0] jal_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus_4,
  output logic [XLEN-1:0] id_instr
);

  localparam int unsigned FQ_PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned FQ_CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int unsigned IF_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned IF_CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned OCC_W    = $clog2(FQ_DEPTH + MAX_OUTSTANDING + 1);

  localparam logic [IF_PTR_W-1:0] IF_PTR_LAST = IF_PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [IF_CNT_W-1:0] IF_CNT_MAX  = IF_CNT_W'(MAX_OUTSTANDING);
  localparam logic [OCC_W-1:0]    OCC_MAX     = OCC_W'(FQ_DEPTH);
  localparam logic [XLEN-1:0]     PC_STEP     = XLEN'(4);

  // Fetch PC
  logic [XLEN-1:0]            r_fetch_pc;

  // In-flight tracker: one entry per accepted, unanswered request
  logic [XLEN-1:0]            r_if_pc [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] r_if_kill;
  logic [IF_PTR_W-1:0]        r_if_wr;
  logic [IF_PTR_W-1:0]        r_if_rd;
  logic [IF_CNT_W-1:0]        r_if_cnt;

  // Fetch queue
  logic [XLEN-1:0]            r_fq_pc    [FQ_DEPTH];
  logic [XLEN-1:0]            r_fq_instr [FQ_DEPTH];
  logic [FQ_PTR_W-1:0]        r_fq_wr;
  logic [FQ_PTR_W-1:0]        r_fq_rd;
  logic [FQ_CNT_W-1:0]        r_fq_cnt;

  logic                       w_redirect;
  logic [XLEN-1:0]            w_sel_target;
  logic [XLEN-1:0]            w_redirect_target;
  logic [OCC_W-1:0]           w_occupancy;
  logic                       w_req_valid;
  logic                       w_issue;
  logic                       w_rsp;
  logic                       w_rsp_keep;
  logic                       w_id_valid;
  logic                       w_id_pop;

  // Tracker depth need not be a power of two, so wrap explicitly.
  function automatic logic [IF_PTR_W-1:0] next_if_ptr(input logic [IF_PTR_W-1:0] p);
    return (p == IF_PTR_LAST) ? '0 : p + IF_PTR_W'(1);
  endfunction

  // Redirect selection: jalr > branch > jal, target word-aligned
  always_comb begin
    w_sel_target = jal_target;
    if (jalr_taken) begin
      w_sel_target = jalr_target;
    end else if (branch_taken) begin
      w_sel_target = branch_target;
    end
  end

  assign w_redirect        = jalr_taken | branch_taken | jal_taken;
  assign w_redirect_target = {w_sel_target[XLEN-1:2], 2'b00};

  // Credit rule: every in-flight request already owns a queue slot, so a
  // non-killed response can always be pushed without checking for full.
  assign w_occupancy = OCC_W'(r_if_cnt) + OCC_W'(r_fq_cnt);
  assign w_req_valid = rst_n & ~w_redirect & (r_if_cnt < IF_CNT_MAX) & (w_occupancy < OCC_MAX);
  assign w_issue     = w_req_valid & imem_req_ready;

  // A response pops the tracker head; it reaches the queue only if that
  // request was not killed and no redirect is flushing the queue this cycle.
  assign w_rsp      = rst_n & imem_rsp_valid & (r_if_cnt != '0);
  assign w_rsp_keep = w_rsp & ~r_if_kill[r_if_rd] & ~w_redirect;

  assign w_id_valid = (r_fq_cnt != '0);
  assign w_id_pop   = w_id_valid & id_ready;

  // Fetch PC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
    end else if (w_redirect) begin
      r_fetch_pc <= w_redirect_target;
    end else if (w_issue) begin
      r_fetch_pc <= r_fetch_pc + PC_STEP;
    end
  end

  // In-flight tracker
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_if_wr   <= '0;
      r_if_rd   <= '0;
      r_if_cnt  <= '0;
      r_if_kill <= '0;
    end else begin
      if (w_issue) begin
        r_if_pc[r_if_wr] <= r_fetch_pc;
        r_if_wr          <= next_if_ptr(r_if_wr);
      end
      if (w_rsp) begin
        r_if_rd <= next_if_ptr(r_if_rd);
      end
      case ({w_issue, w_rsp})
        2'b10:   r_if_cnt <= r_if_cnt + IF_CNT_W'(1);
        2'b01:   r_if_cnt <= r_if_cnt - IF_CNT_W'(1);
        default: r_if_cnt <= r_if_cnt;
      endcase
      // A redirect marks every slot stale; issue cannot coincide with a
      // redirect, so the fresh-entry clear never races the kill.
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        if (w_redirect) begin
          r_if_kill[i] <= 1'b1;
        end else if (w_issue && (r_if_wr == IF_PTR_W'(i))) begin
          r_if_kill[i] <= 1'b0;
        end
      end
    end
  end

  // Fetch queue
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fq_wr  <= '0;
      r_fq_rd  <= '0;
      r_fq_cnt <= '0;
    end else if (w_redirect) begin
      r_fq_wr  <= '0;
      r_fq_rd  <= '0;
      r_fq_cnt <= '0;
    end else begin
      if (w_rsp_keep) begin
        r_fq_pc[r_fq_wr]    <= r_if_pc[r_if_rd];
        r_fq_instr[r_fq_wr] <= imem_rsp_data;
        r_fq_wr             <= r_fq_wr + FQ_PTR_W'(1);
      end
      if (w_id_pop) begin
        r_fq_rd <= r_fq_rd + FQ_PTR_W'(1);
      end
      case ({w_rsp_keep, w_id_pop})
        2'b10:   r_fq_cnt <= r_fq_cnt + FQ_CNT_W'(1);
        2'b01:   r_fq_cnt <= r_fq_cnt - FQ_CNT_W'(1);
        default: r_fq_cnt <= r_fq_cnt;
      endcase
    end
  end

  // Memory must never answer a request that was not made.
  always_ff @(posedge clk) begin
    if (rst_n && imem_rsp_valid) begin
      a_rsp_has_request: assert (r_if_cnt != '0);
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign id_valid       = w_id_valid;

  // Head fields read as zero while the queue is empty.
  always_comb begin
    id_pc        = '0;
    id_pc_plus_4 = '0;
    id_instr     = '0;
    if (w_id_valid) begin
      id_pc        = r_fq_pc[r_fq_rd];
      id_pc_plus_4 = r_fq_pc[r_fq_rd] + PC_STEP;
      id_instr     = r_fq_instr[r_fq_rd];
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        jalr_taken = 1'b0, branch_taken = 1'b0, jal_taken = 1'b0;
  logic [31:0] jalr_target = '0, branch_target = '0, jal_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_pc, id_pc_plus_4, id_instr;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_id_valid;
  logic [31:0] w_id_pc, w_id_pc4, w_id_instr;

  if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FQ_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .jalr_taken(jalr_taken), .jalr_target(jalr_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jal_taken(jal_taken), .jal_target(jal_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_pc_plus_4(id_pc_plus_4), .id_instr(id_instr)
  );

  if_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FQ_DEPTH(4), .MAX_OUTSTANDING(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .jalr_taken(1'b0), .jalr_target(32'h0),
    .branch_taken(1'b0), .branch_target(32'h0),
    .jal_taken(1'b0), .jal_target(32'h0),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .id_valid(w_id_valid), .id_ready(1'b1),
    .id_pc(w_id_pc), .id_pc_plus_4(w_id_pc4), .id_instr(w_id_instr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = 1;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] req_log[$];
  logic [31:0] id_pc_log[$], id_pc4_log[$], id_instr_log[$];

  logic        w_hs = 1'b0;
  logic [31:0] w_hs_addr = '0;
  logic [31:0] w_req_log[$], w_pc_log[$], w_pc4_log[$], w_instr_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Main memory model + request / ID monitors, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + lat);
        req_log.push_back(imem_req_addr);
      end
      if (id_valid && id_ready) begin
        id_pc_log.push_back(id_pc);
        id_pc4_log.push_back(id_pc_plus_4);
        id_instr_log.push_back(id_instr);
      end
    end
    w_hs      = rst_n & w_req_valid;
    w_hs_addr = w_req_addr;
    if (rst_n && w_req_valid && w_req_log.size() < 6) w_req_log.push_back(w_req_addr);
    if (rst_n && w_id_valid && w_pc_log.size() < 6) begin
      w_pc_log.push_back(w_id_pc);
      w_pc4_log.push_back(w_id_pc4);
      w_instr_log.push_back(w_id_instr);
    end
  end

  always @(posedge clk) begin
    #1;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq_addr.pop_front() ^ KEY;
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    w_rsp_valid = w_hs;
    w_rsp_data  = w_hs_addr ^ KEY;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    jalr_taken = 1'b0; branch_taken = 1'b0; jal_taken = 1'b0;
    repeat (3) tick();
    req_log.delete(); id_pc_log.delete(); id_pc4_log.delete(); id_instr_log.delete();
    rst_n = 1'b1;
  endtask

  int          errs;
  int          stall_bad;
  logic [31:0] exp_pc;

  initial begin
    // Reset and first fetches
    lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    @(negedge clk);
    check_eq("rst_req_valid", imem_req_valid, 0);
    check_eq("rst_id_valid", id_valid, 0);
    check_eq("rst_id_pc", id_pc, 0);
    check_eq("rst_id_instr", id_instr, 0);
    tick();
    req_log.delete(); id_pc_log.delete(); id_pc4_log.delete(); id_instr_log.delete();
    w_req_log.delete(); w_pc_log.delete(); w_pc4_log.delete(); w_instr_log.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("first_req_valid", imem_req_valid, 1);
    check_eq("first_req_addr", imem_req_addr, 32'h0);
    tick();
    @(negedge clk);
    check_eq("no_bypass_id_valid", id_valid, 0);
    check_eq("second_req_addr", imem_req_addr, 32'h4);
    tick();
    @(negedge clk);
    check_eq("first_id_valid", id_valid, 1);
    check_eq("first_id_pc", id_pc, 32'h0);
    check_eq("first_id_pc4", id_pc_plus_4, 32'h4);
    check_eq("first_id_instr", id_instr, 32'h1357_9BDF);
    repeat (4) tick();
    check_eq("seq_req0", qget(req_log, 0), 32'h0);
    check_eq("seq_req1", qget(req_log, 1), 32'h4);
    check_eq("seq_req2", qget(req_log, 2), 32'h8);

    // Wrap-around from RESET_PC = 0xFFFF_FFF8 (second instance)
    check_eq("wrap_req_cnt_ok", (w_req_log.size() >= 3), 1);
    check_eq("wrap_req0", qget(w_req_log, 0), 32'hFFFF_FFF8);
    check_eq("wrap_req1", qget(w_req_log, 1), 32'hFFFF_FFFC);
    check_eq("wrap_req2", qget(w_req_log, 2), 32'h0000_0000);
    check_eq("wrap_id_pc1", qget(w_pc_log, 1), 32'hFFFF_FFFC);
    check_eq("wrap_id_pc4_1", qget(w_pc4_log, 1), 32'h0000_0000);
    check_eq("wrap_id_instr1", qget(w_instr_log, 1), 32'hECA8_6423);

    // Backpressure: ID stalled
    id_ready = 1'b0;
    do_reset();
    repeat (12) tick();
    @(negedge clk);
    check_eq("bp_req_count", req_log.size(), 4);
    check_eq("bp_req_valid_low", imem_req_valid, 0);
    check_eq("bp_last_req", qget(req_log, 3), 32'hC);
    check_eq("bp_head_pc", id_pc, 32'h0);
    tick();
    id_ready = 1'b1;
    repeat (8) tick();
    check_eq("bp_drain0", qget(id_pc_log, 0), 32'h0);
    check_eq("bp_drain1", qget(id_pc_log, 1), 32'h4);
    check_eq("bp_drain2", qget(id_pc_log, 2), 32'h8);
    check_eq("bp_drain3", qget(id_pc_log, 3), 32'hC);
    check_eq("bp_drain2_instr", qget(id_instr_log, 2), 32'h1357_9BD7);
    check_eq("bp_resume_req", qget(req_log, 4), 32'h10);

    // Branch redirect with two requests in flight, latency 3
    lat = 3; id_ready = 1'b1; imem_req_ready = 1'b1;
    do_reset();
    jal_taken = 1'b1; jal_target = 32'h20;
    tick();
    jal_taken = 1'b0;
    tick();
    tick();
    branch_taken = 1'b1; branch_target = 32'h100;
    @(negedge clk);
    check_eq("rdr_req_valid_low", imem_req_valid, 0);
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    check_eq("rdr_flushed_t1", id_valid, 0);
    check_eq("rdr_credit_full", imem_req_valid, 0);
    tick();
    @(negedge clk);
    check_eq("rdr_flushed_t2", id_valid, 0);
    check_eq("rdr_next_addr", imem_req_addr, 32'h100);
    repeat (8) tick();
    check_eq("rdr_req_order0", qget(req_log, 0), 32'h20);
    check_eq("rdr_req_order1", qget(req_log, 1), 32'h24);
    check_eq("rdr_req_after", qget(req_log, 2), 32'h100);
    check_eq("rdr_first_id_pc", qget(id_pc_log, 0), 32'h100);
    check_eq("rdr_first_id_instr", qget(id_instr_log, 0), 32'h1357_9ADF);

    // Simultaneous redirects and target alignment
    lat = 1;
    do_reset();
    jalr_taken = 1'b1; jalr_target = 32'h200;
    branch_taken = 1'b1; branch_target = 32'h300;
    jal_taken = 1'b1; jal_target = 32'h400;
    @(negedge clk);
    check_eq("prio_redirect_valid", imem_req_valid, 0);
    tick();
    jalr_taken = 1'b0; branch_taken = 1'b0; jal_taken = 1'b0;
    @(negedge clk);
    check_eq("prio_all_addr", imem_req_addr, 32'h200);
    tick();
    branch_taken = 1'b1; jal_taken = 1'b1;
    tick();
    branch_taken = 1'b0; jal_taken = 1'b0;
    @(negedge clk);
    check_eq("prio_br_jal_addr", imem_req_addr, 32'h300);
    tick();
    jalr_taken = 1'b1; jalr_target = 32'h203;
    tick();
    jalr_taken = 1'b0;
    @(negedge clk);
    check_eq("align_jalr_addr", imem_req_addr, 32'h200);

    // Memory stall for 5 cycles at 0x40
    imem_req_ready = 1'b0;
    do_reset();
    jal_taken = 1'b1; jal_target = 32'h40;
    tick();
    jal_taken = 1'b0;
    stall_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) stall_bad++;
      tick();
    end
    check_eq("stall_hold_bad_cycles", stall_bad, 0);
    imem_req_ready = 1'b1;
    repeat (6) tick();
    check_eq("stall_push0", qget(req_log, 0), 32'h40);
    check_eq("stall_push1", qget(req_log, 1), 32'h44);
    check_eq("stall_id0", qget(id_pc_log, 0), 32'h40);
    check_eq("stall_id1", qget(id_pc_log, 1), 32'h44);

    // Long run across address wrap with both sides stalling
    lat = 2;
    do_reset();
    jal_taken = 1'b1; jal_target = 32'hFFFF_FFF0;
    tick();
    jal_taken = 1'b0;
    for (int i = 0; i < 130; i++) begin
      id_ready       = ((i % 3) != 2);
      imem_req_ready = ((i % 5) != 4);
      tick();
    end
    id_ready = 1'b1; imem_req_ready = 1'b1;
    repeat (10) tick();
    errs = 0;
    for (int k = 0; k < id_pc_log.size(); k++) begin
      exp_pc = 32'hFFFF_FFF0 + 32'(k * 4);
      if (id_pc_log[k] !== exp_pc || id_instr_log[k] !== (exp_pc ^ KEY) ||
          id_pc4_log[k] !== exp_pc + 32'd4) errs++;
    end
    check_eq("long_seq_errs", errs, 0);
    check_eq("long_seq_enough", (id_pc_log.size() >= 40), 1);
    check_eq("long_pc4_of_fffffffc", qget(id_pc4_log, 3), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Parametrised successor to the single-PC instruction fetch stage.
- Decouples PC generation from instruction memory through a valid/ready request channel and an in-order response channel with variable latency.
- Allows up to MAX_OUTSTANDING requests in flight and buffers returned instructions in a fetch queue feeding ID with a valid/ready handshake.
- Redirects (JALR, branch, JAL) flush the queue and kill in-flight responses.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FQ_DEPTH, 4, fetch-queue entries; power of two, >= 2.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests; >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: synchronous, active-low.
- jalr_taken  in  1  JALR redirect from EX.
- jalr_target  in  XLEN  JALR target.
- branch_taken  in  1  branch redirect from EX.
- branch_target  in  XLEN  branch target.
- jal_taken  in  1  JAL redirect from ID.
- jal_target  in  XLEN  JAL target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (bits [1:0] always 0).
- imem_rsp_valid  in  1  response valid; in order, no backpressure.
- imem_rsp_data  in  XLEN  instruction word.
- id_valid  out  1  fetch-queue head valid.
- id_ready  in  1  ID consumes head.
- id_pc  out  XLEN  PC of head instruction.
- id_pc_plus_4  out  XLEN  id_pc + 4 (wraps modulo 2^XLEN).
- id_instr  out  XLEN  head instruction.

Behaviour:
- **Reset** (rst_n=0 at posedge): fetch_pc=RESET_PC; fetch queue and in-flight tracker empty; all kill flags cleared. While rst_n=0, imem_req_valid=0 and id_valid=0. id_pc, id_pc_plus_4 and id_instr are 0 when id_valid=0. Reset mid-operation discards everything; any response arriving during reset is ignored.
- **Redirect priority:** jalr > branch > jal (jalr wins over branch; branch wins over jal). The selected target has bits [1:0] forced to 0.
- **Redirect cycle (any *_taken=1):**
  - imem_req_valid=0.
  - fetch_pc <= selected target.
  - Fetch queue flushed to empty at the clock edge.
  - All in-flight entries get kill=1.
  - A response arriving in the same cycle is dropped.
  - The head handshake in that cycle, if id_valid & id_ready, completes normally.
- **Request issue:**
  - imem_req_valid = rst_n & ~redirect & (inflight_cnt < MAX_OUTSTANDING) & (inflight_cnt + fq_cnt < FQ_DEPTH).
  - imem_req_addr = fetch_pc.
  - On valid & ready: push {pc=fetch_pc, kill=0} into the in-flight tracker; fetch_pc += 4 (wraps).
  - Once asserted, valid and addr stay stable until ready or a redirect.
- **Response:**
  - Each imem_rsp_valid pops the in-flight head.
  - If kill=0: push {pc, instr} into the fetch queue. If kill=1: discard and free the credit only.
  - The credit rule guarantees the queue is never full on a non-killed response. A response with the tracker empty is a protocol error (assertion).
- **Latency:** request accepted at cycle t, response at t+k (k >= 1), id_valid at t+k+1. There is no bypass from response to ID.
- **ID handshake:** id_valid = fq_cnt != 0; pop on id_valid & id_ready. Push and pop in the same cycle keep fq_cnt unchanged.
- **Counters:** same-cycle issue and response leave inflight_cnt unchanged. Read/write pointers are log2(FQ_DEPTH) bits and wrap naturally. Count widths must hold FQ_DEPTH and MAX_OUTSTANDING inclusive.
- **id_ready low indefinitely:** requests stop once inflight_cnt + fq_cnt == FQ_DEPTH; no entry is lost or overwritten.

Test Plan:
- **Reset:** hold rst_n=0 3 cycles, release, imem_req_ready=1, 1-cycle memory -> requests at 0x0, 0x4, 0x8...; first id_valid 2 cycles after the first request, id_pc=0x0, id_pc_plus_4=0x4.
- **Backpressure:** id_ready=0, FQ_DEPTH=4, MAX_OUTSTANDING=2 -> exactly 4 requests issued (0x0–0xC), then imem_req_valid=0. Set id_ready=1 -> instructions drain in order 0x0, 0x4, 0x8, 0xC; issue resumes at 0x10.
- **Redirect with in-flight requests:** memory latency 3, 2 requests outstanding (0x20, 0x24); branch_taken=1 with target 0x100 -> both stale responses dropped, queue empty next cycle, next request 0x100, first id_pc after the redirect = 0x100.
- **Simultaneous redirects:** jalr_taken, branch_taken and jal_taken all =1 (targets 0x200, 0x300, 0x400) -> next request 0x200. With branch+jal only -> 0x300. A jalr_target of 0x203 -> request 0x200.
- **Memory stall:** imem_req_ready=0 for 5 cycles -> imem_req_valid held and imem_req_addr stable at 0x40 throughout; exactly one push of 0x40 when ready rises.
- **Wrap-around:** RESET_PC=0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. id_pc_plus_4 for 0xFFFF_FFFC = 0x0. Queue pointers wrap over 10+ fills without data corruption.
